// File: rtl/result_collector.sv
// rtl/result_collector.sv - reassembles the TPU result byte stream into 16-bit words, double-buffered
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid, in_data[7:0] result bytes, low byte first, c00..c11 (no backpressure)
//   out_valid, out_ready   word handshake to the host-side consumer
//   out_data[15:0]         current word of the drain bank (raw, or clamped with RESULT_SAT_EN)
//   out_idx[1:0], out_last word index within the frame, high on the last word
//   busy                   capture bank holds a partial or a full, not yet drained frame
//   overflow, timeout_err  sticky error flags, cleared by clear_err
// Optional feature macro: RESULT_SAT_EN (clamp out_data to [-128, 127]).
module result_collector #(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        overflow,
  output logic        timeout_err,
  input  logic        clear_err
);

  typedef enum logic [1:0] {CAP_IDLE, CAP_RUN, CAP_HOLD} cap_state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  cap_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0] c_bank_q [4];
  logic [15:0] c_bank_d [4];
  logic [15:0] d_bank_q [4];
  logic [15:0] d_bank_d [4];
  logic        d_valid_q, d_valid_d;
  logic [1:0]  rd_q, rd_d;
  logic        overflow_q, overflow_d;
  logic        timeout_q, timeout_d;

  // Capture bank with the byte currently on the bus merged in; this is what
  // gets written straight into the drain bank on the 8th byte.
  logic [15:0] frame_w [4];
  logic        hs;
  logic        d_free;

  assign hs     = d_valid_q & out_ready;
  // The drain bank counts as free on the same edge its final word is taken.
  assign d_free = ~d_valid_q | (hs & (rd_q == 2'd3));

  always_comb begin
    frame_w = c_bank_q;
    if (cnt_q[0]) frame_w[cnt_q[2:1]][15:8] = in_data;
    else          frame_w[cnt_q[2:1]][7:0]  = in_data;

    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_cnt_d = idle_cnt_q;
    c_bank_d   = c_bank_q;
    d_bank_d   = d_bank_q;
    d_valid_d  = d_valid_q;
    rd_d       = rd_q;
    // Clear first so that a set event on the same edge wins.
    overflow_d = overflow_q & ~clear_err;
    timeout_d  = timeout_q & ~clear_err;

    if (hs) begin
      rd_d = rd_q + 2'd1;
      if (rd_q == 2'd3) d_valid_d = 1'b0;
    end

    // Capture side runs after the drain so a refill overrides the clear above.
    case (state_q)
      CAP_IDLE: begin
        if (in_valid) begin
          c_bank_d   = frame_w;
          cnt_d      = 3'd1;
          idle_cnt_d = 8'd0;
          state_d    = CAP_RUN;
        end
      end
      CAP_RUN: begin
        if (in_valid) begin
          c_bank_d   = frame_w;
          idle_cnt_d = 8'd0;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (d_free) begin
              d_bank_d  = frame_w;
              d_valid_d = 1'b1;
              rd_d      = 2'd0;
              state_d   = CAP_IDLE;
            end else begin
              state_d = CAP_HOLD;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          cnt_d      = 3'd0;
          idle_cnt_d = 8'd0;
          timeout_d  = 1'b1;
          state_d    = CAP_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      CAP_HOLD: begin
        if (in_valid) overflow_d = 1'b1;
        if (d_free) begin
          d_bank_d  = c_bank_q;
          d_valid_d = 1'b1;
          rd_d      = 2'd0;
          state_d   = CAP_IDLE;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAP_IDLE;
      cnt_q      <= 3'd0;
      idle_cnt_q <= 8'd0;
      c_bank_q   <= '{default: 16'h0000};
      d_bank_q   <= '{default: 16'h0000};
      d_valid_q  <= 1'b0;
      rd_q       <= 2'd0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_cnt_q <= idle_cnt_d;
      c_bank_q   <= c_bank_d;
      d_bank_q   <= d_bank_d;
      d_valid_q  <= d_valid_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  logic [15:0] rd_word;
  assign rd_word = d_bank_q[rd_q];

`ifdef RESULT_SAT_EN
  logic signed [15:0] rd_s;
  assign rd_s     = signed'(rd_word);
  assign out_data = (rd_s > 16'sd127)  ? 16'h007F :
                    (rd_s < -16'sd128) ? 16'hFF80 : rd_word;
`else
  assign out_data = rd_word;
`endif

  assign out_valid   = d_valid_q;
  assign out_idx     = rd_q;
  assign out_last    = d_valid_q & (rd_q == 2'd3);
  assign busy        = (state_q != CAP_IDLE);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - self-checking bench for result_collector
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic        timeout_err;
  logic        clear_err = 1'b0;

  int checks = 0;
  int errors = 0;

  // Random phase: scoreboard of expected words and consumer model.
  logic [15:0] exp_q [$];
  int          mon_idx = 0;
  bit          mon_en  = 0;
  bit          rnd_ready = 0;

  result_collector #(.IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat(input logic [15:0] w);
`ifdef RESULT_SAT_EN
    if ($signed(w) > 127)  return 16'h007F;
    if ($signed(w) < -128) return 16'hFF80;
`endif
    return w;
  endfunction

  // Frame packed with byte k at bits [8k+7:8k]; word k is then bits [16k+15:16k].
  function automatic logic [15:0] word_of(input logic [63:0] f, input int k);
    return sat(f[16*k +: 16]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [63:0] f, input int max_gap);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = f[8*k +: 8];
      tick();
      in_valid = 1'b0;
      if (k < 7 && max_gap > 0) begin
        int g = $urandom_range(0, max_gap);
        for (int j = 0; j < g; j++) tick();
      end
    end
  endtask

  task automatic check_word(input string tag, input logic [63:0] f, input int k);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(word_of(f, k)));
    chk({tag, "_idx"},   32'(out_idx),   32'(k));
    chk({tag, "_last"},  32'(out_last),  32'(k == 3));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid),   32'd0);
    chk({tag, "_data"},  32'(out_data),    32'd0);
    chk({tag, "_idx"},   32'(out_idx),     32'd0);
    chk({tag, "_last"},  32'(out_last),    32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_ovf"},   32'(overflow),    32'd0);
    chk({tag, "_tmo"},   32'(timeout_err), 32'd0);
  endtask

  // Consumer-side scoreboard: every handshake must deliver the next expected word.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("rnd_data", 32'(out_data), 32'(exp_q[0]));
        chk("rnd_idx",  32'(out_idx),  32'(mon_idx));
        chk("rnd_last", 32'(out_last), 32'(mon_idx == 3));
        void'(exp_q.pop_front());
        mon_idx = (mon_idx + 1) % 4;
      end
    end
  end

  initial begin
    logic [63:0] fa;
    logic [63:0] fb;
    fa = 64'hDEF0_9ABC_5678_1234;
    fb = 64'h0123_4567_89AB_CDEF;

    // Reset state
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Frame with consumer always ready
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = fa[8*k +: 8]; tick();
    end
    in_valid = 1'b0;
    chk("partial_busy", 32'(busy), 32'd1);
    chk("partial_valid", 32'(out_valid), 32'd0);
    for (int k = 3; k < 8; k++) begin
      in_valid = 1'b1; in_data = fa[8*k +: 8]; tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_word("ready_frame", fa, k);
      tick();
    end
    chk("ready_frame_done", 32'(out_valid), 32'd0);
    chk("ready_frame_ovf", 32'(overflow), 32'd0);
    chk("ready_frame_tmo", 32'(timeout_err), 32'd0);

    // Stalled consumer: word 0 must hold
    out_ready = 1'b0;
    send_frame(fa, 0);
    for (int i = 0; i < 10; i++) begin
      check_word("stall_hold", fa, 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_word("stall_drain", fa, k);
      tick();
    end
    chk("stall_done", 32'(out_valid), 32'd0);

    // Back-to-back frames, held frame, overflow, gapless refill
    out_ready = 1'b0;
    send_frame(fa, 0);
    send_frame(fb, 0);
    chk("hold_busy", 32'(busy), 32'd1);
    check_word("hold_front", fa, 0);
    in_valid = 1'b1; in_data = 8'h55; tick(); in_valid = 1'b0;
    chk("hold_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_word("refill_a", fa, k);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check_word("refill_b", fb, k);
      tick();
    end
    chk("refill_done", 32'(out_valid), 32'd0);
    chk("refill_idle", 32'(busy), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Timeout after 3 bytes and 16 idle cycles
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = fb[8*k +: 8]; tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", 32'(timeout_err), 32'd0);
    chk("tmo_still_busy", 32'(busy), 32'd1);
    tick();
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    send_frame(fa, 0);
    for (int k = 0; k < 4; k++) begin
      check_word("tmo_fresh", fa, k);
      tick();
    end
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("tmo_cleared", 32'(timeout_err), 32'd0);

    // Asynchronous reset mid-frame (cnt=5)
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = fb[8*k +: 8]; tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_frame");
    #2 rst_n = 1'b1;
    tick();
    send_frame(fa, 0);
    for (int k = 0; k < 4; k++) begin
      check_word("after_rst_frame", fa, k);
      tick();
    end

    // Asynchronous reset mid-drain (rd=2)
    out_ready = 1'b0;
    send_frame(fb, 0);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check_word("pre_rst_drain", fb, 2);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_drain");
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_frame(fb, 0);
    for (int k = 0; k < 4; k++) begin
      check_word("after_rst_drain", fb, k);
      tick();
    end

`ifdef RESULT_SAT_EN
    // Saturation of signed words
    send_frame(64'hFF80_007F_FF00_0200, 0);
    chk("sat_w0", 32'(out_data), 32'h007F); tick();
    chk("sat_w1", 32'(out_data), 32'hFF80); tick();
    chk("sat_w2", 32'(out_data), 32'h007F); tick();
    chk("sat_w3", 32'(out_data), 32'hFF80); tick();
`endif

    // Randomized frames, random byte gaps, random consumer backpressure
    mon_idx = 0;
    mon_en = 1;
    rnd_ready = 1;
    for (int n = 0; n < 30; n++) begin
      logic [63:0] f;
      f = {$urandom(), $urandom()};
      begin : wait_cap
        int w = 0;
        while (busy && w < 200) begin tick(); w++; end
        chk("rnd_cap_wait", 32'(busy), 32'd0);
      end
      send_frame(f, 3);
      for (int k = 0; k < 4; k++) exp_q.push_back(word_of(f, k));
    end
    begin : wait_drain
      int w = 0;
      while ((exp_q.size() != 0 || out_valid) && w < 400) begin tick(); w++; end
      chk("rnd_drain_left", 32'(exp_q.size()), 32'd0);
    end
    mon_en = 0;
    rnd_ready = 0;
    chk("rnd_ovf", 32'(overflow), 32'd0);
    chk("rnd_tmo", 32'(timeout_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the TPU top: consumes the byte stream the control unit drives on `uo_out` (four 16-bit accumulations c00, c01, c10, c11, low byte first) and reassembles it into 16-bit results. Results are double-buffered and presented to the host-side consumer through a valid/ready handshake, so the next frame can be captured while the previous one drains. The block also detects stalled frames and overruns.

## Interface
Parameters:
- `IDLE_TIMEOUT`, default 16: cycles without `in_valid` inside a partial frame before the frame is aborted. Legal range 2..255.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_data` holds a result byte this cycle; upstream has no backpressure.
- `in_data`  in  8  result byte.
- `out_valid`  out  1  `out_data` holds a valid result word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  16  result word (raw or saturated, see Configuration).
- `out_idx`  out  2  word index: 0=c00, 1=c01, 2=c10, 3=c11.
- `out_last`  out  1  high when `out_idx==3` and `out_valid`.
- `busy`  out  1  capture has a partial frame or a held full frame.
- `overflow`  out  1  sticky: a byte was dropped because the capture bank was held.
- `timeout_err`  out  1  sticky: a partial frame was aborted by timeout.
- `clear_err`  in  1  clears both sticky flags.

## Operation
- Frame: 8 accepted bytes, byte k → word k>>1. k[0]=0 is bits [7:0] and k[0]=1 is bits [15:8].
- Capture bank C: byte counter `cnt` (0..7), four 16-bit regs, flag `c_full`.
- Drain bank D: four 16-bit regs, flag `d_valid`, read pointer `rd` (0..3).
- Capture FSM:
  - CAP_IDLE (cnt=0): accepted byte → CAP_RUN, cnt=1.
  - CAP_RUN: each accepted byte increments cnt.
  - On the 8th byte (cnt==7 and in_valid), the frame is complete.
    - D free: the complete frame, including the byte on the bus, is written straight into D, `d_valid`=1, `rd`=0, FSM → CAP_IDLE.
    - D not free: the frame stays in C, `c_full`=1, FSM → CAP_HOLD.
  - CAP_HOLD: any in_valid byte is dropped and sets `overflow`. On the edge where D empties, C copies to D, `c_full`=0, FSM → CAP_IDLE.
- "D free" includes the edge where the final D word (rd==3) handshakes.
- Drain:
  - `out_valid`=`d_valid`; `out_data`=D[rd]; `out_idx`=rd.
  - A handshake (out_valid & out_ready) advances rd.
  - The handshake at rd==3 clears `d_valid` unless a refill from C or a direct 8th-byte write happens on the same edge. A refill keeps `out_valid` high with rd=0.
- Timeout:
  - In CAP_RUN, `idle_cnt` increments each cycle without in_valid and resets to 0 on every accepted byte.
  - When idle_cnt reaches IDLE_TIMEOUT-1 and in_valid is low: cnt→0, FSM → CAP_IDLE, `timeout_err` set. Partial C contents are discarded.
  - No timeout in CAP_IDLE or CAP_HOLD.
- Sticky flags: `clear_err` clears both flags on the next edge. If a set event occurs on the same edge, set wins.
- `busy` = (FSM≠CAP_IDLE).

## Timing
- Reset values: all banks zero, cnt=0, rd=0, FSM=CAP_IDLE, all outputs 0.
- Reset is asynchronous and applies mid-frame or mid-drain; it discards everything.
- Latency: 8th byte sampled on edge T → `out_valid`=1 and word 0 on `out_data` from T (registered output, visible in cycle T+1).
- Throughput: with `out_ready` held high, 4 words drain in 4 cycles. Back-to-back frames every 8 cycles never overflow.
- `out_data`/`out_idx` hold stable while `out_valid` is high and `out_ready` is low.

## Configuration
- `RESULT_SAT_EN` defined:
  - `out_data` = D[rd] treated as signed 16-bit, clamped to [-128, 127], sign-extended to 16 bits.
  - Clamping is combinational on the output. Stored bank values remain raw.
- Not defined: `out_data` = raw D[rd].

## Test plan
- Stream bytes 34 12 78 56 BC 9A F0 DE with out_ready=1 → out_data 1234, 5678, 9ABC, DEF0 with idx 0..3 on consecutive cycles, out_last on the 4th word, no flags.
- Same frame with out_ready=0 for 10 cycles → word 0 (1234, idx 0) held stable; with out_ready=1, all 4 words drain in order.
- Two frames back-to-back with out_ready=0 → second frame held (busy=1). A third frame's first byte sets overflow and is dropped. Draining D presents frame 2 with no out_valid gap after the rd==3 handshake.
- 3 bytes, then 16 idle cycles (IDLE_TIMEOUT=16) → timeout_err=1, busy=0. A fresh 8-byte frame is then captured correctly. clear_err with no event clears the flag.
- rst_n pulsed low mid-frame (cnt=5) and mid-drain (rd=2) → all outputs 0 immediately; next frame is captured from byte 0.
- With `RESULT_SAT_EN` defined: words 0x0200, 0xFF00, 0x007F, 0xFF80 → 0x007F, 0xFF80, 0x007F, 0xFF80.
